// File: rtl/pc_seq_pkg.sv
// Shared constants, state encoding and program base lookup for the PC sequencer.
package pc_seq_pkg;

  localparam int PC_W       = 12;
  localparam int LUT_AW     = 5;
  localparam int NUM_LABELS = 7;

  localparam int P0_BASE = 0;
  localparam int P1_BASE = 150;
  localparam int P2_BASE = 620;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only selects 0..2 are legal; callers screen out 3 before using the result.
  function automatic logic [PC_W-1:0] prog_base(input logic [1:0] sel);
    case (sel)
      2'd1:    return PC_W'(P1_BASE);
      2'd2:    return PC_W'(P2_BASE);
      default: return PC_W'(P0_BASE);
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_lut.sv
// Label lookup table: maps a label index to its absolute branch/jump target.
module pc_sequencer_lut
  import pc_seq_pkg::*;
(
  input  logic [LUT_AW-1:0] addr,
  output logic [PC_W-1:0]   Target
);

  // Indices at or above NUM_LABELS are unpopulated; the sequencer flags them before use.
  always_comb begin
    case (addr)
      5'd0:    Target = 12'd5;
      5'd1:    Target = 12'd42;
      5'd2:    Target = 12'd351;
      5'd3:    Target = 12'd700;
      5'd4:    Target = 12'd1000;
      5'd5:    Target = 12'd2047;
      5'd6:    Target = 12'd4095;
      default: Target = '0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, runs the IDLE/RUN/DONE handshake with the
// harness and resolves branch/jump targets through the label LUT.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        ProgSel,
  input  logic              Stall,
  input  logic              Jump_en,
  input  logic              Branch_en,
  input  logic              Cond,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic              Halt_in,
  output logic [PC_W-1:0]   PC,
  output logic              Fetch_vld,
  output logic              Done,
  output logic              Err
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [PC_W-1:0]   lut_target;
  logic              take;
  logic              label_ok;

  pc_sequencer_lut u_lut (
    .addr   (LutAddr),
    .Target (lut_target)
  );

  assign take     = Jump_en | (Branch_en & Cond);
  assign label_ok = LutAddr < LUT_AW'(NUM_LABELS);

  always_comb begin
    // NOTE: every target gets a default hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (ProgSel != 2'd3) begin
            pc_d    = prog_base(ProgSel);
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // Halt wins over any same-cycle jump; a stalled cycle drops all controls.
        if (!Stall) begin
          if (Halt_in) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (take) begin
            if (label_ok) begin
              pc_d = lut_target;
            end else begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!Start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together
  // from values sampled before the edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign PC        = pc_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign Fetch_vld = (state_q == ST_RUN) && !Stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic [1:0]        ProgSel;
  logic              Stall;
  logic              Jump_en;
  logic              Branch_en;
  logic              Cond;
  logic [LUT_AW-1:0] LutAddr;
  logic              Halt_in;
  logic [PC_W-1:0]   PC;
  logic              Fetch_vld;
  logic              Done;
  logic              Err;

  pc_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ProgSel   (ProgSel),
    .Stall     (Stall),
    .Jump_en   (Jump_en),
    .Branch_en (Branch_en),
    .Cond      (Cond),
    .LutAddr   (LutAddr),
    .Halt_in   (Halt_in),
    .PC        (PC),
    .Fetch_vld (Fetch_vld),
    .Done      (Done),
    .Err       (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: program phase as an int, PC as an int taken modulo 4096.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int label_tbl [7] = '{5, 42, 351, 700, 1000, 2047, 4095};
  int base_tbl  [3] = '{0, 150, 620};

  int m_phase;
  int m_pc;
  int m_done;
  int m_err;

  int n_cmp;
  int n_mis;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    if (!Reset) begin
      m_phase = M_IDLE;
      m_pc    = 0;
      m_done  = 0;
      m_err   = 0;
    end else if (m_phase == M_IDLE) begin
      if (Start) begin
        if (ProgSel < 3) begin
          m_pc    = base_tbl[ProgSel];
          m_phase = M_RUN;
        end else begin
          m_err   = 1;
          m_done  = 1;
          m_phase = M_DONE;
        end
      end
    end else if (m_phase == M_RUN) begin
      if (!Stall) begin
        if (Halt_in) begin
          m_done  = 1;
          m_phase = M_DONE;
        end else if (Jump_en || (Branch_en && Cond)) begin
          if (LutAddr < 7) m_pc = label_tbl[LutAddr];
          else begin
            m_err   = 1;
            m_done  = 1;
            m_phase = M_DONE;
          end
        end else begin
          m_pc = (m_pc + 1) % 4096;
        end
      end
    end else begin
      if (!Start) begin
        m_done  = 0;
        m_err   = 0;
        m_phase = M_IDLE;
      end
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare
  // shortly after the edge while those inputs are still applied.
  task automatic cycle(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check({tag, " pc"},    int'(PC),        m_pc);
    check({tag, " done"},  int'(Done),      m_done);
    check({tag, " err"},   int'(Err),       m_err);
    check({tag, " fetch"}, int'(Fetch_vld), (m_phase == M_RUN && !Stall) ? 1 : 0);
  endtask

  task automatic clear_ctl();
    Stall     = 1'b0;
    Jump_en   = 1'b0;
    Branch_en = 1'b0;
    Cond      = 1'b0;
    Halt_in   = 1'b0;
    LutAddr   = '0;
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    m_phase = M_IDLE;
    m_pc    = 0;
    m_done  = 0;
    m_err   = 0;
    Reset   = 1'b0;
    Start   = 1'b0;
    ProgSel = 2'd0;
    clear_ctl();

    cycle("reset0");
    cycle("reset1");

    // Start program 1, then step up to 160.
    Reset   = 1'b1;
    Start   = 1'b1;
    ProgSel = 2'd1;
    cycle("start_p1");
    check("p1_base_abs", int'(PC), 150);
    for (int i = 0; i < 10; i++) cycle("incr");
    check("pc160_abs", int'(PC), 160);

    Jump_en = 1'b1; LutAddr = 5'd2;
    cycle("jump_l2");
    check("jump_l2_abs", int'(PC), 351);
    Jump_en = 1'b0; Branch_en = 1'b1; Cond = 1'b0; LutAddr = 5'd9;
    cycle("branch_nt");
    Cond = 1'b1; LutAddr = 5'd5;
    cycle("branch_t");
    clear_ctl();

    // Halt beats a same-cycle jump; Start held keeps DONE.
    Halt_in = 1'b1; Jump_en = 1'b1; LutAddr = 5'd4;
    cycle("halt_jump");
    clear_ctl();
    cycle("done_hold0");
    cycle("done_hold1");
    Start = 1'b0;
    cycle("to_idle");

    // Illegal label and illegal program select.
    Start = 1'b1; ProgSel = 2'd0;
    cycle("start_p0");
    Jump_en = 1'b1; LutAddr = 5'd9;
    cycle("bad_label");
    clear_ctl(); Start = 1'b0;
    cycle("clear_err");
    Start = 1'b1; ProgSel = 2'd3;
    cycle("bad_sel");
    Start = 1'b0;
    cycle("clear_err2");

    // Stall freezes everything; PC wraps from 4095.
    Start = 1'b1; ProgSel = 2'd2;
    cycle("start_p2");
    Jump_en = 1'b1; LutAddr = 5'd6;
    cycle("jump_l6");
    Stall = 1'b1; Halt_in = 1'b1;
    for (int i = 0; i < 3; i++) cycle("stall");
    clear_ctl();
    cycle("wrap");
    check("wrap_abs", int'(PC), 0);

    // First unpopulated label index.
    Jump_en = 1'b1; LutAddr = 5'd7;
    cycle("label7");
    clear_ctl(); Start = 1'b0;
    cycle("clear_err3");

    // Reset in the middle of a run.
    Start = 1'b1; ProgSel = 2'd0;
    cycle("start_p0b");
    Jump_en = 1'b1; LutAddr = 5'd3;
    cycle("jump_l3");
    clear_ctl();
    Reset = 1'b0;
    cycle("mid_reset");
    Reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      Reset     = ($urandom_range(0, 63) != 0);
      Start     = ($urandom_range(0, 3) != 0);
      ProgSel   = 2'($urandom_range(0, 3));
      Stall     = ($urandom_range(0, 3) == 0);
      Jump_en   = ($urandom_range(0, 7) == 0);
      Branch_en = ($urandom_range(0, 3) == 0);
      Cond      = 1'($urandom_range(0, 1));
      Halt_in   = ($urandom_range(0, 31) == 0);
      LutAddr   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(0, 6));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
